// File: rtl/book_pkg.sv
// Shared types and helpers for the order reference map and downstream book logic.
package book_pkg;

    localparam logic BUY  = 1'b1;
    localparam logic SELL = 1'b0;

    typedef struct packed {
        logic [63:0] refNum;
        logic [15:0] locate;
        logic [31:0] price;
        logic [31:0] shares;
        logic        buySell;
    } orderEntryType;

    typedef struct packed {
        logic        add;
        logic        side;
        logic [15:0] locate;
        logic [31:0] price;
        logic [31:0] shares;
    } bookUpdateType;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_ADD,
        OP_DEL,
        OP_EXEC
    } evtOpType;

    // XOR-fold of the 64-bit reference into addr_w-bit chunks; the top chunk is
    // implicitly zero-padded. Callers keep only the low addr_w bits.
    function automatic logic [31:0] ref_hash(input logic [63:0] ref_num, input int addr_w);
        logic [31:0] h;
        int          b;
        h = '0;
        for (int i = 0; i < 64; i++) begin
            b = i % addr_w;
            h[b[4:0]] = h[b[4:0]] ^ ref_num[i];
        end
        return h;
    endfunction

endpackage

// File: rtl/order_ref_map_if.sv
// Parser-event inputs and book-update outputs of order_ref_map.
interface order_ref_map_if;
    logic        addValidIn;
    logic        delValidIn;
    logic        execValidIn;
    logic [63:0] refNumIn;
    logic [15:0] locateIn;
    logic [31:0] priceIn;
    logic [31:0] sharesIn;
    logic        buySellIn;
    logic        updValidOut;
    logic        updAddOut;
    logic        updSideOut;
    logic [15:0] updLocateOut;
    logic [31:0] updPriceOut;
    logic [31:0] updSharesOut;
    logic        missOut;
    logic        collisionOut;

    modport master (
        output addValidIn, delValidIn, execValidIn, refNumIn, locateIn,
               priceIn, sharesIn, buySellIn,
        input  updValidOut, updAddOut, updSideOut, updLocateOut,
               updPriceOut, updSharesOut, missOut, collisionOut
    );

    modport slave (
        input  addValidIn, delValidIn, execValidIn, refNumIn, locateIn,
               priceIn, sharesIn, buySellIn,
        output updValidOut, updAddOut, updSideOut, updLocateOut,
               updPriceOut, updSharesOut, missOut, collisionOut
    );
endinterface

// File: rtl/order_ref_ram.sv
// Simple dual-port entry store: one write port, one registered read port, no reset.
module order_ref_ram #(
    parameter int ADDR_W = 10,
    parameter int WIDTH  = 145
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);
    logic [WIDTH-1:0] mem [2**ADDR_W];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_q <= mem[raddr];
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/order_ref_map.sv
// Direct-mapped refNum table: turns add/delete/exec parser events into book updates.
module order_ref_map
    import book_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic           clkIn,
    input  logic           rstIn,
    order_ref_map_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [31:0]       hash_full;
    logic [ADDR_W-1:0] s0_idx;
    logic              unused_hash_bits;

    assign hash_full        = ref_hash(bus.refNumIn, ADDR_W);
    assign s0_idx           = hash_full[ADDR_W-1:0];
    assign unused_hash_bits = ^hash_full[31:ADDR_W];

    evtOpType          s1_op_q, s1_op_d;
    logic [ADDR_W-1:0] s1_idx_q, s1_idx_d;
    orderEntryType     s1_evt_q, s1_evt_d;
    logic              s1_slot_valid_q, s1_slot_valid_d;
    logic              s1_fwd_q, s1_fwd_d;
    orderEntryType     s1_fwd_entry_q, s1_fwd_entry_d;
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic              upd_valid_q, upd_valid_d;
    bookUpdateType     upd_q, upd_d;
    logic              miss_q, miss_d;
    logic              collision_q, collision_d;

    logic              ram_we;
    orderEntryType     ram_wdata;
    logic [$bits(orderEntryType)-1:0] ram_rdata_raw;
    orderEntryType     ram_rdata;
    orderEntryType     stored;
    logic              hit;

    assign ram_rdata = ram_rdata_raw;

    order_ref_ram #(
        .ADDR_W (ADDR_W),
        .WIDTH  ($bits(orderEntryType))
    ) u_ram (
        .clk   (clkIn),
        .we    (ram_we),
        .waddr (s1_idx_q),
        .wdata (ram_wdata),
        .raddr (s0_idx),
        .rdata (ram_rdata_raw)
    );

    always_comb begin
        s1_op_d = OP_NONE;
        if (bus.addValidIn && !bus.delValidIn && !bus.execValidIn) s1_op_d = OP_ADD;
        if (!bus.addValidIn && bus.delValidIn && !bus.execValidIn) s1_op_d = OP_DEL;
        if (!bus.addValidIn && !bus.delValidIn && bus.execValidIn) s1_op_d = OP_EXEC;
        s1_idx_d = s0_idx;
        s1_evt_d = '{refNum: bus.refNumIn, locate: bus.locateIn, price: bus.priceIn,
                     shares: bus.sharesIn, buySell: bus.buySellIn};

        stored      = s1_fwd_q ? s1_fwd_entry_q : ram_rdata;
        hit         = s1_slot_valid_q && (stored.refNum == s1_evt_q.refNum);
        valid_d     = valid_q;
        ram_we      = 1'b0;
        ram_wdata   = s1_evt_q;
        upd_valid_d = 1'b0;
        upd_d       = '0;
        miss_d      = 1'b0;
        collision_d = 1'b0;

        case (s1_op_q)
            OP_ADD: begin
                if (!s1_slot_valid_q || hit) begin
                    ram_we            = 1'b1;
                    valid_d[s1_idx_q] = 1'b1;
                    upd_valid_d       = 1'b1;
                    upd_d = '{add: 1'b1, side: s1_evt_q.buySell, locate: s1_evt_q.locate,
                              price: s1_evt_q.price, shares: s1_evt_q.shares};
                end else begin
                    collision_d = 1'b1;
                end
            end
            OP_DEL: begin
                if (hit) begin
                    valid_d[s1_idx_q] = 1'b0;
                    upd_valid_d       = 1'b1;
                    upd_d = '{add: 1'b0, side: stored.buySell, locate: stored.locate,
                              price: stored.price, shares: stored.shares};
                end else begin
                    miss_d = 1'b1;
                end
            end
            OP_EXEC: begin
                if (!hit) begin
                    miss_d = 1'b1;
                end else if (s1_evt_q.shares != 32'd0) begin
                    upd_valid_d = 1'b1;
                    upd_d = '{add: 1'b0, side: stored.buySell, locate: stored.locate,
                              price: stored.price, shares: stored.shares};
                    if (s1_evt_q.shares < stored.shares) begin
                        ram_we           = 1'b1;
                        ram_wdata        = stored;
                        ram_wdata.shares = stored.shares - s1_evt_q.shares;
                        upd_d.shares     = s1_evt_q.shares;
                    end else begin
                        valid_d[s1_idx_q] = 1'b0;
                    end
                end
            end
            default: ;
        endcase

        // Forward this cycle's write-back into the read now entering S1.
        s1_slot_valid_d = valid_d[s0_idx];
        s1_fwd_d        = ram_we && (s1_idx_q == s0_idx);
        s1_fwd_entry_d  = ram_wdata;
    end

    always_ff @(posedge clkIn or posedge rstIn) begin
        if (rstIn) begin
            s1_op_q         <= OP_NONE;
            s1_idx_q        <= '0;
            s1_evt_q        <= '0;
            s1_slot_valid_q <= 1'b0;
            s1_fwd_q        <= 1'b0;
            s1_fwd_entry_q  <= '0;
            valid_q         <= '0;
            upd_valid_q     <= 1'b0;
            upd_q           <= '0;
            miss_q          <= 1'b0;
            collision_q     <= 1'b0;
        end else begin
            s1_op_q         <= s1_op_d;
            s1_idx_q        <= s1_idx_d;
            s1_evt_q        <= s1_evt_d;
            s1_slot_valid_q <= s1_slot_valid_d;
            s1_fwd_q        <= s1_fwd_d;
            s1_fwd_entry_q  <= s1_fwd_entry_d;
            valid_q         <= valid_d;
            upd_valid_q     <= upd_valid_d;
            upd_q           <= upd_d;
            miss_q          <= miss_d;
            collision_q     <= collision_d;
        end
    end

    assign bus.updValidOut  = upd_valid_q;
    assign bus.updAddOut    = upd_q.add;
    assign bus.updSideOut   = upd_q.side;
    assign bus.updLocateOut = upd_q.locate;
    assign bus.updPriceOut  = upd_q.price;
    assign bus.updSharesOut = upd_q.shares;
    assign bus.missOut      = miss_q;
    assign bus.collisionOut = collision_q;
endmodule

// File: tb/tb_order_ref_map.sv
// Directed bench for order_ref_map: hand-computed book updates, misses and collisions.
module tb_order_ref_map;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    order_ref_map_if bus();

    order_ref_map #(.ADDR_W(10)) dut (
        .clkIn (clk),
        .rstIn (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #2 clk = ~clk;

    localparam logic [63:0] REF_A = 64'hDEFB1673DEFB1673;
    localparam logic [63:0] REF_B = 64'h0000000000001234;
    localparam logic [63:0] REF_C = 64'h00000000CAFEF00D;
    localparam logic [63:0] REF_D = 64'h0000000000055AA5;
    localparam logic [63:0] REF_E = 64'h000000000000BEEF;
    localparam logic [63:0] REF_F = 64'h0123456789ABCDEF;
    localparam logic [63:0] REF_X = 64'hDEF12373DEFDE89C;
    localparam logic [63:0] REF_0 = 64'h0;
    localparam logic [63:0] REF_K = 64'h0000000000000401;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic a, input logic d, input logic e, input logic [63:0] r,
                         input logic [15:0] loc, input logic [31:0] pr, input logic [31:0] sh,
                         input logic bs);
        bus.addValidIn  = a;
        bus.delValidIn  = d;
        bus.execValidIn = e;
        bus.refNumIn    = r;
        bus.locateIn    = loc;
        bus.priceIn     = pr;
        bus.sharesIn    = sh;
        bus.buySellIn   = bs;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 64'h0, 16'h0, 32'h0, 32'h0, 1'b0);
    endtask

    // Apply one event for one cycle and advance to the cycle its result appears.
    task automatic run_evt(input logic a, input logic d, input logic e, input logic [63:0] r,
                           input logic [15:0] loc, input logic [31:0] pr, input logic [31:0] sh,
                           input logic bs);
        drive(a, d, e, r, loc, pr, sh, bs);
        step();
        idle();
        step();
    endtask

    task automatic expect_upd(input string tag, input logic v, input logic a, input logic s,
                              input logic [15:0] loc, input logic [31:0] pr,
                              input logic [31:0] sh, input logic m, input logic c);
        check_eq({tag, ".valid"}, 64'(bus.updValidOut), 64'(v));
        check_eq({tag, ".miss"}, 64'(bus.missOut), 64'(m));
        check_eq({tag, ".collision"}, 64'(bus.collisionOut), 64'(c));
        if (v) begin
            check_eq({tag, ".add"}, 64'(bus.updAddOut), 64'(a));
            check_eq({tag, ".side"}, 64'(bus.updSideOut), 64'(s));
            check_eq({tag, ".locate"}, 64'(bus.updLocateOut), 64'(loc));
            check_eq({tag, ".price"}, 64'(bus.updPriceOut), 64'(pr));
            check_eq({tag, ".shares"}, 64'(bus.updSharesOut), 64'(sh));
        end
        $display("txn %s: valid=%0b add=%0b side=%0b loc=%0h price=%0h shares=%0d miss=%0b coll=%0b",
                 tag, bus.updValidOut, bus.updAddOut, bus.updSideOut, bus.updLocateOut,
                 bus.updPriceOut, bus.updSharesOut, bus.missOut, bus.collisionOut);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        idle();
        repeat (3) step();
        expect_upd("reset", 1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        check_eq("reset.add_field", 64'(bus.updAddOut), 64'h0);
        check_eq("reset.shares_field", 64'(bus.updSharesOut), 64'h0);
        rst = 1'b0;
        step();

        run_evt(1, 0, 0, REF_A, 16'hBE42, 32'h0022FEFC, 32'd45, 1'b1);
        expect_upd("add_A", 1, 1, 1, 16'hBE42, 32'h0022FEFC, 32'd45, 0, 0);
        run_evt(0, 1, 0, REF_A, 16'h0, 32'h0, 32'h0, 1'b0);
        expect_upd("del_A", 1, 0, 1, 16'hBE42, 32'h0022FEFC, 32'd45, 0, 0);
        run_evt(0, 1, 0, REF_A, 16'h0, 32'h0, 32'h0, 1'b0);
        expect_upd("del_A_again", 0, 0, 0, 16'h0, 32'h0, 32'h0, 1, 0);

        run_evt(1, 0, 0, REF_B, 16'h0007, 32'd1000, 32'd100, 1'b0);
        expect_upd("add_B", 1, 1, 0, 16'h0007, 32'd1000, 32'd100, 0, 0);
        run_evt(0, 0, 1, REF_B, 16'h0, 32'h0, 32'd30, 1'b0);
        expect_upd("exec_B_30", 1, 0, 0, 16'h0007, 32'd1000, 32'd30, 0, 0);
        run_evt(0, 0, 1, REF_B, 16'h0, 32'h0, 32'd100, 1'b0);
        expect_upd("exec_B_100", 1, 0, 0, 16'h0007, 32'd1000, 32'd70, 0, 0);
        run_evt(0, 1, 0, REF_B, 16'h0, 32'h0, 32'h0, 1'b0);
        expect_upd("del_B_freed", 0, 0, 0, 16'h0, 32'h0, 32'h0, 1, 0);

        // Add immediately followed by delete of the same ref.
        drive(1, 0, 0, REF_C, 16'h0C0C, 32'h00001111, 32'd77, 1'b1);
        step();
        drive(0, 1, 0, REF_C, 16'h0, 32'h0, 32'h0, 1'b0);
        step();
        idle();
        expect_upd("b2b_add_C", 1, 1, 1, 16'h0C0C, 32'h00001111, 32'd77, 0, 0);
        step();
        expect_upd("b2b_del_C", 1, 0, 1, 16'h0C0C, 32'h00001111, 32'd77, 0, 0);

        // Refs 0 and 0x401 fold to the same slot; second add collides.
        drive(1, 0, 0, REF_0, 16'h0001, 32'd5, 32'd10, 1'b1);
        step();
        drive(1, 0, 0, REF_K, 16'h0002, 32'd6, 32'd20, 1'b0);
        step();
        idle();
        expect_upd("add_0", 1, 1, 1, 16'h0001, 32'd5, 32'd10, 0, 0);
        step();
        expect_upd("add_401_coll", 0, 0, 0, 16'h0, 32'h0, 32'h0, 0, 1);
        run_evt(0, 1, 0, REF_0, 16'h0, 32'h0, 32'h0, 1'b0);
        expect_upd("del_0", 1, 0, 1, 16'h0001, 32'd5, 32'd10, 0, 0);

        run_evt(1, 0, 0, REF_D, 16'h00DD, 32'd4242, 32'd9, 1'b0);
        expect_upd("add_D", 1, 1, 0, 16'h00DD, 32'd4242, 32'd9, 0, 0);
        run_evt(0, 0, 1, REF_D, 16'h0, 32'h0, 32'd0, 1'b0);
        expect_upd("exec_D_zero", 0, 0, 0, 16'h0, 32'h0, 32'h0, 0, 0);
        run_evt(1, 1, 0, REF_D, 16'h0, 32'h0, 32'h0, 1'b0);
        expect_upd("multi_strobe", 0, 0, 0, 16'h0, 32'h0, 32'h0, 0, 0);
        run_evt(0, 1, 0, REF_D, 16'h0, 32'h0, 32'h0, 1'b0);
        expect_upd("del_D", 1, 0, 0, 16'h00DD, 32'd4242, 32'd9, 0, 0);

        run_evt(0, 1, 0, REF_X, 16'h0, 32'h0, 32'h0, 1'b0);
        expect_upd("del_X_never", 0, 0, 0, 16'h0, 32'h0, 32'h0, 1, 0);
        run_evt(0, 0, 1, REF_X, 16'h0, 32'h0, 32'd5, 1'b0);
        expect_upd("exec_X_never", 0, 0, 0, 16'h0, 32'h0, 32'h0, 1, 0);

        run_evt(1, 0, 0, REF_E, 16'h00EE, 32'd300, 32'd3, 1'b1);
        expect_upd("add_E", 1, 1, 1, 16'h00EE, 32'd300, 32'd3, 0, 0);
        run_evt(1, 0, 0, REF_F, 16'h00FF, 32'd400, 32'd4, 1'b0);
        expect_upd("add_F", 1, 1, 0, 16'h00FF, 32'd400, 32'd4, 0, 0);
        rst = 1'b1;
        #1;
        expect_upd("async_reset", 0, 0, 0, 16'h0, 32'h0, 32'h0, 0, 0);
        check_eq("async_reset.shares_field", 64'(bus.updSharesOut), 64'h0);
        step();
        rst = 1'b0;
        step();
        run_evt(0, 1, 0, REF_E, 16'h0, 32'h0, 32'h0, 1'b0);
        expect_upd("del_E_after_rst", 0, 0, 0, 16'h0, 32'h0, 32'h0, 1, 0);
        run_evt(0, 1, 0, REF_F, 16'h0, 32'h0, 32'h0, 1'b0);
        expect_upd("del_F_after_rst", 0, 0, 0, 16'h0, 32'h0, 32'h0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
